br_unit: RTL and testbench
==========================

BR_UNIT -- requirements
Module: br_unit

Interface
REQ-001 SHALL have parameter DATAW, default 32, meaning operand/address width (>=8).
REQ-002 SHALL have port clk, in, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, in, 1; reset is synchronous and active-low.
REQ-004 SHALL have ports in_valid (in, 1) and in_ready (out, 1), the request handshake.
REQ-005 SHALL have port op, in, 2: 00 = conditional branch, 01 = JAL, 10 = JALR, 11 = reserved.
REQ-006 SHALL have port funct3, in, 3: branch condition EQ=000, NE=001, LT=100, GE=101, LTU=110, GEU=111.
REQ-007 SHALL have ports a and b (in, DATAW) as rs1/rs2 operands, pc (in, DATAW), and imm (in, DATAW, sign-extended).
REQ-008 SHALL have ports pred_taken (in, 1) and pred_target (in, DATAW), the fetch-stage prediction.
REQ-009 SHALL have port flush, in, 1, which kills the held and incoming results.
REQ-010 SHALL have ports out_valid (out, 1) and out_ready (in, 1), the result handshake.
REQ-011 SHALL have outputs out_taken (1), out_target (DATAW), out_link (DATAW), out_mispredict (1), out_redirect (DATAW) and out_illegal (1).

Function
REQ-012 SHALL accept a request when in_valid && in_ready; in_ready = !out_valid || out_ready (single output register, full throughput, no combinational in_valid->out_valid path).
REQ-013 SHALL present the result registered exactly 1 cycle after acceptance; outputs SHALL hold stable while out_valid && !out_ready.
REQ-014 SHALL compute taken for op=00 per funct3 (signed compare for LT/GE, unsigned for LTU/GEU); funct3 010/011 -> taken=0 and out_illegal=1.
REQ-015 SHALL force taken=1 for op=01/10; op=11 -> taken=0 and out_illegal=1.
REQ-016 SHALL compute target = pc+imm for op=00/01 and (a+imm) with bit0 cleared for op=10; all sums are modulo 2^DATAW (wrap, no carry out).
REQ-017 SHALL compute out_link = pc+4 modulo 2^DATAW.
REQ-018 SHALL set out_mispredict = (taken != pred_taken) || (taken && target != pred_target); illegal requests SHALL force out_mispredict=0.
REQ-019 SHALL set out_redirect = target if taken, else out_link.
REQ-020 SHALL, when flush=1, clear out_valid on the next edge and discard any request accepted in the same cycle; flush takes priority over acceptance and over out_ready.
REQ-021 SHALL, when out_valid && out_ready && a new request is accepted in the same cycle, replace the result back-to-back with out_valid staying 1.

Reset
REQ-022 SHALL, while rst_n=0 at an edge, clear out_valid, out_taken, out_mispredict, out_illegal and zero out_target, out_link and out_redirect.
REQ-023 SHALL drop a result in flight when reset is asserted mid-operation; the first accept is possible on the first edge after rst_n=1.
REQ-024 SHALL give in_ready = 1 during and immediately after reset, because out_valid=0.

Configuration
REQ-025 SHALL, with BR_UNIT_PERF_EN defined, add outputs perf_br (32) and perf_mispred (32), counting each consumed result (out_valid && out_ready && !flush) and each consumed result with out_mispredict=1, respectively.
REQ-026 SHALL make both counters reset to 0, saturate at 2^32-1, and ignore illegal results.
REQ-027 SHALL, without BR_UNIT_PERF_EN, have no perf ports and no counter logic; all other behaviour is identical.

Verification
REQ-028 SHALL cover: op=00, funct3=100, a=0xFFFFFFFF, b=1, pc=0x100, imm=0x20, pred_taken=0 -> 1 cycle later out_taken=1, out_target=0x120, out_mispredict=1, out_redirect=0x120.
REQ-029 SHALL cover: funct3=110 with the same operands -> out_taken=0, out_redirect=0x104, out_mispredict=0.
REQ-030 SHALL cover: op=10, a=0x1001, imm=0x4, pred_taken=1, pred_target=0x1004 -> out_target=0x1004, out_link=pc+4, out_mispredict=0; pc=0xFFFFFFFC -> out_link=0.
REQ-031 SHALL cover: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs frozen; then out_ready=1 -> back-to-back results, none lost or duplicated.
REQ-032 SHALL cover: flush in the same cycle as an accept -> out_valid=0 next cycle; funct3=011 -> out_illegal=1, out_mispredict=0.
REQ-033 SHALL cover: with BR_UNIT_PERF_EN, 5 consumed results with 2 mispredicted plus 1 flushed -> perf_br=5, perf_mispred=2; rst_n=0 -> both 0.

Source files
------------

// File: rtl/br_unit.sv
// br_unit: resolves branches/jumps and holds one registered result behind a valid/ready handshake.
// Optional performance counters are built when BR_UNIT_PERF_EN is defined.
module br_unit #(
   parameter int DATAW = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [2:0]       funct3,
   input  logic [DATAW-1:0] a,
   input  logic [DATAW-1:0] b,
   input  logic [DATAW-1:0] pc,
   input  logic [DATAW-1:0] imm,
   input  logic             pred_taken,
   input  logic [DATAW-1:0] pred_target,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_taken,
   output logic [DATAW-1:0] out_target,
   output logic [DATAW-1:0] out_link,
   output logic             out_mispredict,
   output logic [DATAW-1:0] out_redirect,
   output logic             out_illegal
`ifdef BR_UNIT_PERF_EN
   ,
   output logic [31:0]      perf_br,
   output logic [31:0]      perf_mispred
`endif
);

   logic             r_valid;
   logic             r_taken;
   logic             r_mispred;
   logic             r_illegal;
   logic [DATAW-1:0] r_target;
   logic [DATAW-1:0] r_link;
   logic [DATAW-1:0] r_redirect;

   logic             w_accept;
   logic             w_taken;
   logic             w_illegal;
   logic             w_mispred;
   logic [DATAW-1:0] w_target;
   logic [DATAW-1:0] w_link;
   logic [DATAW-1:0] w_redirect;
   logic [DATAW-1:0] w_jalrSum;

   // The single output slot can take a new request whenever it is empty or being drained.
   assign in_ready  = !r_valid || out_ready;
   assign w_accept  = in_valid && in_ready;
   assign w_jalrSum = a + imm;
   assign w_link    = pc + DATAW'(4);

   always_comb begin
      w_taken   = 1'b0;
      w_illegal = 1'b0;
      w_target  = pc + imm;
      case (op)
         2'b00: begin
            case (funct3)
               3'b000:  w_taken = (a == b);
               3'b001:  w_taken = (a != b);
               3'b100:  w_taken = ($signed(a) < $signed(b));
               3'b101:  w_taken = ($signed(a) >= $signed(b));
               3'b110:  w_taken = (a < b);
               3'b111:  w_taken = (a >= b);
               default: w_illegal = 1'b1;
            endcase
         end
         2'b01: w_taken = 1'b1;
         2'b10: begin
            w_taken  = 1'b1;
            w_target = {w_jalrSum[DATAW-1:1], 1'b0};
         end
         default: w_illegal = 1'b1;
      endcase
   end

   assign w_mispred  = !w_illegal &&
                       ((w_taken != pred_taken) || (w_taken && (w_target != pred_target)));
   assign w_redirect = w_taken ? w_target : w_link;

   // Flush outranks both a new accept and a drain; data is only reloaded on accept.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid    <= 1'b0;
         r_taken    <= 1'b0;
         r_mispred  <= 1'b0;
         r_illegal  <= 1'b0;
         r_target   <= '0;
         r_link     <= '0;
         r_redirect <= '0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_accept) begin
         r_valid    <= 1'b1;
         r_taken    <= w_taken;
         r_mispred  <= w_mispred;
         r_illegal  <= w_illegal;
         r_target   <= w_target;
         r_link     <= w_link;
         r_redirect <= w_redirect;
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign out_valid      = r_valid;
   assign out_taken      = r_taken;
   assign out_mispredict = r_mispred;
   assign out_illegal    = r_illegal;
   assign out_target     = r_target;
   assign out_link       = r_link;
   assign out_redirect   = r_redirect;

`ifdef BR_UNIT_PERF_EN
   logic        w_consume;
   logic [31:0] r_perfBr;
   logic [31:0] r_perfMispred;

   assign w_consume = r_valid && out_ready && !flush && !r_illegal;

   // Saturating counters of consumed legal results and of those that were mispredicted.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_perfBr      <= '0;
         r_perfMispred <= '0;
      end else if (w_consume) begin
         if (r_perfBr != '1) begin
            r_perfBr <= r_perfBr + 32'd1;
         end
         if (r_mispred && (r_perfMispred != '1)) begin
            r_perfMispred <= r_perfMispred + 32'd1;
         end
      end
   end

   assign perf_br      = r_perfBr;
   assign perf_mispred = r_perfMispred;
`endif

endmodule

// File: tb/tb_br_unit.sv
// tb_br_unit: directed and randomized checks of br_unit against a behavioural model.
// Perf counter checks are compiled in when BR_UNIT_PERF_EN is defined.
module tb_br_unit;

   localparam int DATAW = 32;

   typedef struct packed {
      logic [1:0]  op;
      logic [2:0]  funct3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] pc;
      logic [31:0] imm;
      logic        pt;
      logic [31:0] ptgt;
   } req_t;

   typedef struct packed {
      logic        taken;
      logic [31:0] target;
      logic        targetKnown;
      logic [31:0] link;
      logic        mispred;
      logic [31:0] redirect;
      logic        illegal;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  op;
   logic [2:0]  funct3;
   logic [31:0] a, b, pc, imm;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic        out_taken;
   logic [31:0] out_target;
   logic [31:0] out_link;
   logic        out_mispredict;
   logic [31:0] out_redirect;
   logic        out_illegal;
`ifdef BR_UNIT_PERF_EN
   logic [31:0] perf_br;
   logic [31:0] perf_mispred;
`endif

   int checks = 0;
   int errors = 0;

   br_unit #(.DATAW(DATAW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .funct3(funct3), .a(a), .b(b), .pc(pc), .imm(imm),
      .pred_taken(pred_taken), .pred_target(pred_target),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_taken(out_taken), .out_target(out_target), .out_link(out_link),
      .out_mispredict(out_mispredict), .out_redirect(out_redirect),
      .out_illegal(out_illegal)
`ifdef BR_UNIT_PERF_EN
      , .perf_br(perf_br), .perf_mispred(perf_mispred)
`endif
   );

   always #5 clk = ~clk;

   // Reference: results computed from the architectural rules with wide arithmetic.
   function automatic exp_t refModel(req_t r);
      exp_t       e;
      logic [63:0] wide;
      bit         legal;
      e = '0;
      legal = 1'b1;
      e.targetKnown = 1'b1;
      wide = (64'(r.pc) + 64'd4) % 64'h1_0000_0000;
      e.link = wide[31:0];
      wide = (64'(r.pc) + 64'(r.imm)) % 64'h1_0000_0000;
      e.target = wide[31:0];
      case (r.op)
         2'd0: begin
            case (r.funct3)
               3'd0: e.taken = (r.a == r.b);
               3'd1: e.taken = (r.a != r.b);
               3'd4: e.taken = ($signed(r.a) < $signed(r.b));
               3'd5: e.taken = !($signed(r.a) < $signed(r.b));
               3'd6: e.taken = (r.a < r.b);
               3'd7: e.taken = !(r.a < r.b);
               default: legal = 1'b0;
            endcase
         end
         2'd1: e.taken = 1'b1;
         2'd2: begin
            e.taken = 1'b1;
            wide = (64'(r.a) + 64'(r.imm)) % 64'h1_0000_0000;
            wide = (wide / 2) * 2;
            e.target = wide[31:0];
         end
         default: begin
            legal = 1'b0;
            e.targetKnown = 1'b0;
         end
      endcase
      e.illegal  = !legal;
      e.mispred  = legal && ((e.taken != r.pt) || (e.taken && (e.target != r.ptgt)));
      e.redirect = e.taken ? e.target : e.link;
      return e;
   endfunction

   function automatic req_t mkReq(logic [1:0] o, logic [2:0] f, logic [31:0] ra, logic [31:0] rb,
                                  logic [31:0] rpc, logic [31:0] rimm, logic rpt, logic [31:0] rptgt);
      req_t r;
      r.op = o; r.funct3 = f; r.a = ra; r.b = rb; r.pc = rpc; r.imm = rimm;
      r.pt = rpt; r.ptgt = rptgt;
      return r;
   endfunction

   function automatic req_t randReq();
      req_t r;
      exp_t e;
      r.op     = 2'($urandom_range(0, 3));
      r.funct3 = 3'($urandom_range(0, 7));
      r.a      = $urandom;
      r.b      = ($urandom_range(0, 3) == 0) ? r.a : $urandom;
      r.pc     = $urandom;
      r.imm    = $urandom;
      r.pt     = 1'($urandom_range(0, 1));
      r.ptgt   = $urandom;
      e = refModel(r);
      if ($urandom_range(0, 1) == 1) r.ptgt = e.target;
      return r;
   endfunction

   task automatic applyStimulus(input req_t r, input logic v);
      in_valid    = v;
      op          = r.op;
      funct3      = r.funct3;
      a           = r.a;
      b           = r.b;
      pc          = r.pc;
      imm         = r.imm;
      pred_taken  = r.pt;
      pred_target = r.ptgt;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkResult(input string tag, input exp_t e);
      checkOutput({tag, " taken"},    32'(out_taken),      32'(e.taken));
      if (e.targetKnown) checkOutput({tag, " target"}, out_target, e.target);
      checkOutput({tag, " link"},     out_link,            e.link);
      checkOutput({tag, " mispred"},  32'(out_mispredict), 32'(e.mispred));
      checkOutput({tag, " redirect"}, out_redirect,        e.redirect);
      checkOutput({tag, " illegal"},  32'(out_illegal),    32'(e.illegal));
   endtask

   task automatic sendDirected(input string tag, input req_t r);
      applyStimulus(r, 1'b1);
      out_ready = 1'b1;
      flush     = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      checkOutput({tag, " valid"}, 32'(out_valid), 32'd1);
      checkResult(tag, refModel(r));
   endtask

   req_t  r28, r29, r30, r30w, rIll, rOp3, rs;
   exp_t  sq[$];
   int    accepted = 0;
   int    consumed = 0;

   initial begin
      r28  = mkReq(2'b00, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 1'b0, 32'h0);
      r29  = mkReq(2'b00, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 1'b0, 32'h0);
      r30  = mkReq(2'b10, 3'b000, 32'h1001, 32'h0, 32'h200, 32'h4, 1'b1, 32'h1004);
      r30w = mkReq(2'b10, 3'b000, 32'h1001, 32'h0, 32'hFFFF_FFFC, 32'h4, 1'b1, 32'h1004);
      rIll = mkReq(2'b00, 3'b011, 32'h5, 32'h5, 32'h40, 32'h8, 1'b1, 32'h48);
      rOp3 = mkReq(2'b11, 3'b000, 32'h5, 32'h5, 32'h40, 32'h8, 1'b1, 32'h48);

      // Reset dominates an incoming request.
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
      applyStimulus(r28, 1'b1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkOutput("reset valid",    32'(out_valid),      32'd0);
      checkOutput("reset in_ready", 32'(in_ready),       32'd1);
      checkOutput("reset taken",    32'(out_taken),      32'd0);
      checkOutput("reset target",   out_target,          32'd0);
      checkOutput("reset link",     out_link,            32'd0);
      checkOutput("reset redirect", out_redirect,        32'd0);
      checkOutput("reset mispred",  32'(out_mispredict), 32'd0);
      checkOutput("reset illegal",  32'(out_illegal),    32'd0);

      // First accept on the first edge after release.
      rst_n = 1'b1;
      checkOutput("post-reset in_ready", 32'(in_ready), 32'd1);
      sendDirected("blt", r28);
      sendDirected("bltu", r29);
      sendDirected("jalr", r30);
      sendDirected("jalr wrap", r30w);
      sendDirected("funct3 011", rIll);
      sendDirected("op 11", rOp3);

      // Flush coinciding with an accept leaves nothing valid.
      applyStimulus(r28, 1'b1);
      flush = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      checkOutput("flush+accept valid", 32'(out_valid), 32'd0);

      // Flush kills a held result even with out_ready low.
      flush = 1'b0; out_ready = 1'b0;
      applyStimulus(r29, 1'b1);
      @(posedge clk); #1;
      checkOutput("held valid", 32'(out_valid), 32'd1);
      in_valid = 1'b0; flush = 1'b1;
      @(posedge clk); #1;
      checkOutput("held flushed", 32'(out_valid), 32'd0);
      flush = 1'b0;

      // Reset in the middle of an operation drops the held result.
      applyStimulus(r30, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      checkOutput("pre-reset valid", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      checkOutput("mid reset valid",    32'(out_valid), 32'd0);
      checkOutput("mid reset in_ready", 32'(in_ready),  32'd1);
      rst_n = 1'b1;

      // Random stream with periodic stalls, tracked by a one-deep scoreboard.
      for (int cyc = 0; cyc < 400; cyc++) begin
         logic vin, ordy, acc;
         rs   = randReq();
         vin  = ($urandom_range(0, 3) != 0);
         ordy = ((cyc % 16) < 4) ? 1'b0 : ($urandom_range(0, 3) != 0);
         applyStimulus(rs, vin);
         out_ready = ordy;
         #1;
         acc = vin && ((sq.size() == 0) || ordy);
         checkOutput("stream in_ready",  32'(in_ready),  32'((sq.size() == 0) || ordy));
         checkOutput("stream out_valid", 32'(out_valid), 32'(sq.size() != 0));
         if (sq.size() != 0) begin
            checkResult("stream", sq[0]);
            if (ordy) begin
               void'(sq.pop_front());
               consumed++;
            end
         end
         if (acc) begin
            sq.push_back(refModel(rs));
            accepted++;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      if (sq.size() != 0) begin
         checkResult("stream drain", sq[0]);
         void'(sq.pop_front());
         consumed++;
      end
      @(posedge clk); #1;
      checkOutput("stream drained", 32'(out_valid), 32'd0);
      checkOutput("stream count",   32'(consumed),  32'(accepted));

`ifdef BR_UNIT_PERF_EN
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      checkOutput("perf reset br",      perf_br,      32'd0);
      checkOutput("perf reset mispred", perf_mispred, 32'd0);
      sendDirected("perf1", r28);
      sendDirected("perf2", r29);
      sendDirected("perf3", rIll);
      sendDirected("perf4", r28);
      sendDirected("perf5", r29);
      sendDirected("perf6", r30);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      applyStimulus(r28, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      checkOutput("perf br",      perf_br,      32'd5);
      checkOutput("perf mispred", perf_mispred, 32'd2);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      checkOutput("perf cleared br",      perf_br,      32'd0);
      checkOutput("perf cleared mispred", perf_mispred, 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
